// File: rtl/demux1x3_router.sv
// One-to-three stream distributor: each accepted beat is steered by in_sel into a
// one-entry registered buffer per output channel; select 2'b11 beats are dropped and counted.
module demux1x3_router #(
    parameter int DATA_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    input  logic [1:0]        in_sel,
    output logic              in_ready,
    output logic              out0_valid,
    output logic [DATA_W-1:0] out0_data,
    input  logic              out0_ready,
    output logic              out1_valid,
    output logic [DATA_W-1:0] out1_data,
    input  logic              out1_ready,
    output logic              out2_valid,
    output logic [DATA_W-1:0] out2_data,
    input  logic              out2_ready,
    output logic              err_flag,
    output logic [ERR_W-1:0]  err_count
);

    // Handshake: a beat moves on any interface in the cycle where its valid and
    // ready are both high at the rising edge; valid never waits on ready.

    localparam logic [1:0] SEL_ILLEGAL = 2'b11;

    logic [2:0]        buf_valid;
    logic [DATA_W-1:0] buf_data [3];
    logic [2:0]        ch_ready;
    logic [2:0]        wr;
    logic [2:0]        drain;
    logic              in_fire;
    logic              illegal_fire;

    assign ch_ready = {out2_ready, out1_ready, out0_ready};
    assign in_fire  = in_valid & in_ready;

    // Readiness looks only at the addressed channel so one stalled consumer
    // cannot hold up traffic bound for the others.
    always_comb begin
        in_ready = 1'b1;
        case (in_sel)
            2'd0:    in_ready = !buf_valid[0] | ch_ready[0];
            2'd1:    in_ready = !buf_valid[1] | ch_ready[1];
            2'd2:    in_ready = !buf_valid[2] | ch_ready[2];
            default: in_ready = 1'b1;
        endcase
    end

    assign illegal_fire = in_fire & (in_sel == SEL_ILLEGAL);

    for (genvar k = 0; k < 3; k++) begin : g_ch
        assign wr[k]    = in_fire & (in_sel == 2'(k));
        assign drain[k] = buf_valid[k] & ch_ready[k];

        // A write wins over a same-cycle drain so back-to-back beats leave no bubble.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                buf_valid[k] <= 1'b0;
                buf_data[k]  <= '0;
            end else if (wr[k]) begin
                buf_valid[k] <= 1'b1;
                buf_data[k]  <= in_data;
            end else if (drain[k]) begin
                buf_valid[k] <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err_flag  <= 1'b0;
            err_count <= '0;
        end else if (illegal_fire) begin
            err_flag <= 1'b1;
            if (err_count != {ERR_W{1'b1}}) begin
                err_count <= err_count + 1'b1;
            end
        end
    end

    assign out0_valid = buf_valid[0];
    assign out0_data  = buf_data[0];
    assign out1_valid = buf_valid[1];
    assign out1_data  = buf_data[1];
    assign out2_valid = buf_valid[2];
    assign out2_data  = buf_data[2];

endmodule

// File: tb/tb_demux1x3_router.sv
// Directed bench for demux1x3_router: drivers push expected beats into per-channel
// queues and a negedge monitor pops and compares whatever the channels present.
module tb_demux1x3_router;

    localparam int DW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic [1:0]    in_sel;
    logic          in_ready;
    logic          out0_valid, out1_valid, out2_valid;
    logic [DW-1:0] out0_data, out1_data, out2_data;
    logic          out0_ready, out1_ready, out2_ready;
    logic          err_flag;
    logic [7:0]    err_count;

    logic          sat_in_ready;
    logic          sat_out0_valid, sat_out1_valid, sat_out2_valid;
    logic [DW-1:0] sat_out0_data, sat_out1_data, sat_out2_data;
    logic          sat_err_flag;
    logic [1:0]    sat_err_count;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] exp_q [3][$];
    logic [7:0]    hist;

    always #5 clk = ~clk;

    demux1x3_router #(.DATA_W(DW), .ERR_W(8)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_sel(in_sel), .in_ready(in_ready),
        .out0_valid(out0_valid), .out0_data(out0_data), .out0_ready(out0_ready),
        .out1_valid(out1_valid), .out1_data(out1_data), .out1_ready(out1_ready),
        .out2_valid(out2_valid), .out2_data(out2_data), .out2_ready(out2_ready),
        .err_flag(err_flag), .err_count(err_count)
    );

    demux1x3_router #(.DATA_W(DW), .ERR_W(2)) u_sat (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_data(in_data), .in_sel(in_sel), .in_ready(sat_in_ready),
        .out0_valid(sat_out0_valid), .out0_data(sat_out0_data), .out0_ready(out0_ready),
        .out1_valid(sat_out1_valid), .out1_data(sat_out1_data), .out1_ready(out1_ready),
        .out2_valid(sat_out2_valid), .out2_data(sat_out2_data), .out2_ready(out2_ready),
        .err_flag(sat_err_flag), .err_count(sat_err_count)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: any presented beat must match the head of its queue; pop on transfer.
    task automatic mon_ch(input int k, input logic v, input logic r, input logic [DW-1:0] d);
        if (v) begin
            if (exp_q[k].size() == 0) begin
                checks++;
                errors++;
                $display("FAIL ch%0d_unexpected: got beat 0x%0h, expected no beat", k, d);
            end else begin
                check($sformatf("ch%0d_data", k), 32'(d), 32'(exp_q[k][0]));
                if (r) void'(exp_q[k].pop_front());
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst) begin
            for (int k = 0; k < 3; k++) exp_q[k].delete();
        end else begin
            mon_ch(0, out0_valid, out0_ready, out0_data);
            mon_ch(1, out1_valid, out1_ready, out1_data);
            mon_ch(2, out2_valid, out2_ready, out2_data);
        end
    end

    // Called at posedge+1; returns at posedge+1 after the accepting edge, valid left high.
    task automatic send(input logic [1:0] sel, input logic [DW-1:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_sel   = sel;
        in_data  = d;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n >= 20) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: got in_ready 0 for %0d cycles, expected 1 (sel %0d)", n, sel);
                in_valid = 1'b0;
                return;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        if (sel != 2'b11) exp_q[sel].push_back(d);
        #1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) begin
            in_sel  = 2'($urandom_range(0, 3));
            in_data = 8'($urandom_range(0, 255));
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        rst = 1'b1;
        in_valid = 1'b0; in_data = '0; in_sel = '0;
        out0_ready = 1'b1; out1_ready = 1'b1; out2_ready = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        @(posedge clk); #1;

        // Reset state after 10 idle cycles
        idle(10);
        check("rst_out0_valid", 32'(out0_valid), 0);
        check("rst_out1_valid", 32'(out1_valid), 0);
        check("rst_out2_valid", 32'(out2_valid), 0);
        check("rst_out0_data",  32'(out0_data), 0);
        check("rst_out1_data",  32'(out1_data), 0);
        check("rst_out2_data",  32'(out2_data), 0);
        check("rst_err_flag",   32'(err_flag), 0);
        check("rst_err_count",  32'(err_count), 0);
        for (int s = 0; s < 4; s++) begin
            in_sel = 2'(s);
            #1;
            check($sformatf("rst_in_ready_sel%0d", s), 32'(in_ready), 1);
        end
        @(posedge clk); #1;

        // Basic routing on consecutive cycles
        send(2'd0, 8'hA5);
        send(2'd2, 8'h3C);
        send(2'd1, 8'hFF);
        idle(3);

        // Backpressure isolation
        out1_ready = 1'b0;
        send(2'd1, 8'h11);
        in_valid = 1'b1; in_sel = 2'd1; in_data = 8'h22;
        @(negedge clk);
        check("bp_in_ready_ch1_full", 32'(in_ready), 0);
        check("bp_out1_held", 32'(out1_valid), 1);
        @(posedge clk); #1;
        send(2'd0, 8'h33);
        out1_ready = 1'b1;
        send(2'd1, 8'h22);
        idle(3);

        // Back-to-back writes with the consumer draining every cycle
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    hist[i] = out2_valid;
                end
            end
        join_none
        send(2'd2, 8'h01);
        send(2'd2, 8'h02);
        send(2'd2, 8'h03);
        send(2'd2, 8'h04);
        idle(6);
        check("ch2_no_bubble", 32'(hist), 32'h1E);

        // Illegal select: three beats, then two more to saturate the 2-bit counter
        for (int i = 0; i < 3; i++) send(2'b11, 8'(8'hE0 + i));
        idle(1);
        check("ill_err_flag", 32'(err_flag), 1);
        check("ill_err_count3", 32'(err_count), 3);
        check("ill_sat_count3", 32'(sat_err_count), 3);
        for (int i = 0; i < 2; i++) send(2'b11, 8'(8'hF0 + i));
        idle(1);
        check("ill_err_count5", 32'(err_count), 5);
        check("ill_sat_saturated", 32'(sat_err_count), 3);
        check("ill_sat_flag", 32'(sat_err_flag), 1);

        // Reset mid-operation with two loaded, stalled channels
        out0_ready = 1'b0; out2_ready = 1'b0;
        send(2'd0, 8'h55);
        send(2'd2, 8'h66);
        idle(1);
        check("pre_rst_out0_valid", 32'(out0_valid), 1);
        check("pre_rst_out2_valid", 32'(out2_valid), 1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_out0_valid", 32'(out0_valid), 0);
        check("async_rst_out0_data",  32'(out0_data), 0);
        check("async_rst_out2_valid", 32'(out2_valid), 0);
        check("async_rst_out2_data",  32'(out2_data), 0);
        check("async_rst_err_count",  32'(err_count), 0);
        check("async_rst_err_flag",   32'(err_flag), 0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst = 1'b0;
        out0_ready = 1'b1; out2_ready = 1'b1;
        @(posedge clk); #1;
        idle(5);

        for (int k = 0; k < 3; k++)
            check($sformatf("ch%0d_queue_drained", k), 32'(exp_q[k].size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL global_timeout: got no end of test, expected completion");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/demux1x3_router.md
Name: demux1x3_router

Overview:
- Single-stream to three-stream distributor: the inverse of the 3:1 selector.
- Each input beat is routed, under a 2-bit select, to one of three output channels. Each output channel has a one-entry registered buffer with valid/ready flow control.
- Illegal select values are accepted, dropped and counted.
- Sits downstream of a single producer and fans its data out to three consumers.

Parameters:
- DATA_W, 8, width of the data path on the input and on every output.
- ERR_W, 8, width of the saturating illegal-select counter.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- in_valid  input  1  input beat present.
- in_data  input  DATA_W  input payload.
- in_sel  input  2  destination: 00 = ch0, 01 = ch1, 10 = ch2, 11 = illegal.
- in_ready  output  1  block can accept the beat this cycle.
- out0_valid / out1_valid / out2_valid  output  1 each  channel buffer holds data.
- out0_data / out1_data / out2_data  output  DATA_W each  channel buffer payload.
- out0_ready / out1_ready / out2_ready  input  1 each  consumer takes the beat.
- err_flag  output  1  sticky; set on the first accepted illegal-select beat.
- err_count  output  ERR_W  number of accepted illegal-select beats, saturating.

Behaviour:
- Reset (async assert, release synchronous to clk):
  - all outK_valid = 0, all outK_data = 0.
  - err_flag = 0, err_count = 0.
  - Reset mid-transfer discards all buffered beats; no output beat survives reset.
- Transfer rules:
  - Input transfer occurs when in_valid & in_ready.
  - Output transfer on channel K occurs when outK_valid & outK_ready.
- in_ready is combinational:
  - in_sel = 11: in_ready = 1.
  - otherwise: in_ready = !outK_valid | outK_ready, for K = in_sel.
  - in_ready depends only on the selected channel; a full, stalled ch1 never blocks traffic to ch0 or ch2.
- Latency:
  - A beat accepted at edge N appears on outK_valid/outK_data after edge N (1-cycle latency).
  - Throughput is 1 beat/cycle per channel when the consumer holds ready high.
- Per-channel buffer next state:
  - write & drain (same cycle): valid stays 1, data takes the new beat (no bubble).
  - write only: valid becomes 1, data takes the new beat.
  - drain only: valid becomes 0, data holds its last value.
  - neither: hold.
- Data stability: outK_data must not change while outK_valid = 1 and outK_ready = 0.
- Illegal select (in_sel = 11):
  - The beat is consumed and not written to any channel.
  - err_flag is set.
  - err_count increments by 1 and saturates at 2^ERR_W - 1 (no wrap).
- No effect when idle:
  - A change of in_sel while in_valid = 0 has no effect.
  - in_data is ignored when in_valid = 0.
- Per-cycle limits: at most one channel is written per cycle. Drains on all three channels may happen in the same cycle.
- No combinational path from in_data to any output; all outK_* come from registers.

Test Plan:
- Reset, then 10 cycles idle:
  - all outK_valid = 0, all outK_data = 0x00.
  - in_ready = 1 for every in_sel.
  - err_flag = 0, err_count = 0.
- Basic routing, all out ready = 1:
  - Send 0xA5 with sel = 00, then 0x3C with sel = 10, then 0xFF with sel = 01 on consecutive cycles.
  - Expect out0 = 0xA5 one cycle after acceptance, then out2 = 0x3C, then out1 = 0xFF.
  - Each channel's valid is high for exactly 1 cycle.
- Backpressure isolation:
  - Hold out1_ready = 0. Send 0x11 and then 0x22, both with sel = 01.
  - Expect 0x11 buffered and in_ready = 0 while sel = 01.
  - With sel switched to 00, send 0x33: it is accepted and appears on out0.
  - Raise out1_ready: 0x11 drains, then 0x22 is accepted and appears on out1 next cycle.
- Simultaneous write and drain:
  - out2_ready = 1; stream 0x01, 0x02, 0x03, 0x04 to sel = 10 on back-to-back cycles.
  - Expect out2_valid continuously high for 4 cycles with data 01, 02, 03, 04 and no bubble.
- Illegal select:
  - Send 3 beats with sel = 11.
  - Expect in_ready = 1 throughout, no outK_valid asserted, err_flag = 1, err_count = 3.
  - With ERR_W = 2, send 5 illegal beats: err_count saturates at 3.
- Reset mid-operation:
  - Load ch0 = 0x55 and ch2 = 0x66 with readys held low.
  - Assert rst asynchronously between edges: outputs clear immediately, before the next edge.
  - After release, no stale beat is ever presented on any channel.
